prefix_diff: RTL and testbench

//   Inverse of the PrefixSum datapath. It takes a stream of running (prefix) sums and

---
 rtl/prefix_diff_if.sv | 33 +++
 rtl/prefix_diff.sv | 137 +++++++++++++
 tb/tb_prefix_diff.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_diff_if.sv
// prefix_diff_if
//   Bundles the upstream and downstream handshake signals of prefix_diff.
//   Handshake rule on both sides: a beat transfers on a rising clk edge when
//   its valid is high and the matching ready is high. The sender holds its
//   data stable while valid is high and ready is low.
//   Upstream:   IN_valid / IN_data / IN_restart  -> block,  OUT_ready <- block
//   Downstream: OUT_valid / OUT_data -> consumer,  IN_ready <- consumer
//   Status:     OUT_count (FIFO occupancy), OUT_err (sticky monotonic error)
//   Modports: slave = the prefix_diff block, master = the environment around it.
interface prefix_diff_if #(
  parameter int N     = 32,
  parameter int DEPTH = 2
);
  logic                       IN_valid;
  logic [N-1:0]               IN_data;
  logic                       IN_restart;
  logic                       OUT_ready;
  logic                       OUT_valid;
  logic [N-1:0]               OUT_data;
  logic                       IN_ready;
  logic [$clog2(DEPTH+1)-1:0] OUT_count;
  logic                       OUT_err;

  modport slave (
    input  IN_valid, IN_data, IN_restart, IN_ready,
    output OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_err
  );

  modport master (
    output IN_valid, IN_data, IN_restart, IN_ready,
    input  OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_err
  );
endinterface

// File: rtl/prefix_diff.sv
// prefix_diff
//   Turns a stream of running (prefix) sums back into the original addends by
//   emitting IN_data[k] - IN_data[k-1] (mod 2^N). Results go through a small
//   output FIFO so downstream stalls do not immediately stall upstream.
//   Ports:
//     clk, rst_n      single clock, asynchronous active-low reset
//     bus (slave)     IN_valid/IN_data/IN_restart/OUT_ready upstream side,
//                     OUT_valid/OUT_data/IN_ready downstream side,
//                     OUT_count occupancy, OUT_err sticky error
//   Parameters: N data width, DEPTH FIFO entries (2..16).
//   Optional feature macro: PREFIX_DIFF_MONO_CHECK_EN
//     When defined, a non-restart beat whose sum is below the previous sum
//     sets OUT_err (sticky until reset) and triggers a simulation assertion.
//     When undefined, OUT_err is tied low.
module prefix_diff #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  prefix_diff_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [N-1:0]  prev;
  logic [N-1:0]  head;
  logic [N-1:0]  head_nxt;
  logic [N-1:0]  base;
  logic [N-1:0]  diff;
  logic          ready;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, so a pop on a full FIFO
  // frees the slot for the following cycle, never the current one.
  assign ready = (count < DEPTH_C);
  assign push  = bus.IN_valid && ready;
  assign pop   = (count != '0) && bus.IN_ready;

  assign base = bus.IN_restart ? '0 : prev;
  assign diff = bus.IN_data - base;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (pop) rd_ptr_nxt = ptr_inc(rd_ptr);
  end

  // OUT_data comes from its own register. Its next value is whatever entry
  // sits at the next read pointer; if that slot is being written this edge
  // the incoming diff is forwarded into the head register (no same-cycle
  // bypass to the output).
  always_comb begin
    head_nxt = head;
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = diff;
    end else if (count_nxt != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
      prev   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= diff;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
      // A restart without an accepted beat still clears the history, so the
      // next beat is differenced against zero.
      if (push) begin
        prev <= bus.IN_data;
      end else if (bus.IN_restart) begin
        prev <= '0;
      end
    end
  end

  assign bus.OUT_ready = ready;
  assign bus.OUT_valid = (count != '0);
  assign bus.OUT_data  = head;
  assign bus.OUT_count = count;

`ifdef PREFIX_DIFF_MONO_CHECK_EN
  logic mono_viol;
  logic err_q;

  assign mono_viol = push && !bus.IN_restart && (bus.IN_data < prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mono_viol) begin
      err_q <= 1'b1;
    end
  end

  assign bus.OUT_err = err_q;

  a_monotonic: assert property (@(posedge clk) disable iff (!rst_n) !mono_viol)
    else $error("prefix_diff: non-monotonic prefix sum accepted");
`else
  assign bus.OUT_err = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_diff.sv
module tb_prefix_diff;
  localparam int N     = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prefix_diff_if #(.N(N), .DEPTH(DEPTH)) bus ();

  prefix_diff #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string tag);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out waiting for DUT at %0t", tag, $time);
  endtask

  // ---------------- downstream ready driver ----------------
  // 0: hold low, 1: hold high, 2: random (mostly high)
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.IN_ready = 1'b0;
      1:       bus.IN_ready = 1'b1;
      default: bus.IN_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- reference model / scoreboard ----------------
  // Occupancy, ready and valid follow from the queue of outstanding diffs.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] m_prev = '0;
  logic         m_err  = 1'b0;
  logic         m_acc;
  logic         m_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_prev = '0;
      m_err  = 1'b0;
    end else begin
      check_eq("count", 32'(bus.OUT_count), 32'(exp_q.size()));
      check_eq("valid", 32'(bus.OUT_valid), 32'(exp_q.size() != 0));
      check_eq("ready", 32'(bus.OUT_ready), 32'(exp_q.size() < DEPTH));
      check_eq("err",   32'(bus.OUT_err),   32'(m_err));
      if (exp_q.size() != 0) check_eq("data", bus.OUT_data, exp_q[0]);
      m_acc = bus.IN_valid && (exp_q.size() < DEPTH);
      m_pop = (exp_q.size() != 0) && bus.IN_ready;
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back(bus.IN_data - (bus.IN_restart ? '0 : m_prev));
`ifdef PREFIX_DIFF_MONO_CHECK_EN
        if (!bus.IN_restart && (bus.IN_data < m_prev)) m_err = 1'b1;
`endif
        m_prev = bus.IN_data;
      end else if (bus.IN_restart) begin
        m_prev = '0;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic r);
    int   budget;
    logic was_ready;
    budget         = 200;
    bus.IN_valid   = 1'b1;
    bus.IN_data    = d;
    bus.IN_restart = r;
    while (1) begin
      @(negedge clk);
      was_ready = bus.OUT_ready;
      @(posedge clk);
      #1;
      if (was_ready) break;
      budget--;
      if (budget == 0) begin
        fail_timeout("send");
        break;
      end
    end
    bus.IN_valid   = 1'b0;
    bus.IN_restart = 1'b0;
  endtask

  task automatic pulse_restart();
    bus.IN_restart = 1'b1;
    @(posedge clk);
    #1;
    bus.IN_restart = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 500;
    while (b > 0) begin
      @(negedge clk);
      if (bus.OUT_count == '0) break;
      b--;
    end
    if (b == 0) fail_timeout("drain");
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] run_sum;

  initial begin
    bus.IN_valid   = 1'b0;
    bus.IN_data    = '0;
    bus.IN_restart = 1'b0;

    // reset state
    #2;
    check_eq("rst_valid", 32'(bus.OUT_valid), 32'd0);
    check_eq("rst_count", 32'(bus.OUT_count), 32'd0);
    check_eq("rst_data",  bus.OUT_data,       32'd0);
    check_eq("rst_err",   32'(bus.OUT_err),   32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic differences, first beat uses base 0
    rdy_mode = 1;
    send(32'd3, 1'b0);
    send(32'd10, 1'b0);
    send(32'd10, 1'b0);
    send(32'd25, 1'b0);
    wait_drain();

    // 2: modular wrap
    send(32'hFFFF_FFF0, 1'b1);
    send(32'h0000_0010, 1'b0);
    wait_drain();

    // 3: stalled downstream, FIFO fills then drains in order
    rdy_mode = 0;
    idle(2);
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'(200 + i * 7), (i == 0));
      end
      begin
        idle(6);
        @(negedge clk);
        check_eq("stall_count", 32'(bus.OUT_count), 32'(DEPTH));
        check_eq("stall_ready", 32'(bus.OUT_ready), 32'd0);
        rdy_mode = 1;
      end
    join
    wait_drain();

    // 4: restart with a beat, and a standalone restart pulse
    send(32'd100, 1'b1);
    send(32'd150, 1'b0);
    send(32'd40, 1'b1);
    send(32'd45, 1'b0);
    wait_drain();
    send(32'd500, 1'b0);
    pulse_restart();
    send(32'd9, 1'b0);
    wait_drain();

    // 5: reset mid-stream with full FIFO
    rdy_mode = 0;
    idle(2);
    send(32'd11, 1'b0);
    send(32'd22, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus.OUT_valid), 32'd0);
    check_eq("midrst_count", 32'(bus.OUT_count), 32'd0);
    check_eq("midrst_data",  bus.OUT_data,       32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send(32'd7, 1'b0);
    wait_drain();

    // 6: non-monotonic pair
    send(32'd20, 1'b1);
    send(32'd15, 1'b0);
    send(32'd30, 1'b0);
    wait_drain();
`ifdef PREFIX_DIFF_MONO_CHECK_EN
    check_eq("mono_err", 32'(bus.OUT_err), 32'd1);
`else
    check_eq("mono_err", 32'(bus.OUT_err), 32'd0);
`endif

    // randomized traffic with random downstream stalls
    rdy_mode = 2;
    run_sum  = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) begin
        pulse_restart();
        run_sum = '0;
      end
      if ($urandom_range(0, 9) == 0) begin
        run_sum = $urandom_range(0, 1000);
        send(run_sum, 1'b1);
      end else begin
        if ($urandom_range(0, 4) == 0) run_sum = $urandom();
        else run_sum = run_sum + N'($urandom_range(0, 5000));
        send(run_sum, 1'b0);
      end
    end
    rdy_mode = 1;
    wait_drain();
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
